// File: rtl/rounding_arbiter.sv
// ----------------------------------------------------------------------------
// rounding_arbiter
//   Shares one signed_rounder between N_REQ requesters. A round-robin arbiter
//   accepts at most one request per cycle into an issue register; a tag
//   pipeline carries the owner ID (and, with saturation, the input sign)
//   alongside the rounder so every registered result leaves with its ID.
//
// Optional feature macro: ROUNDING_ARB_SAT_EN
//   defined     : positive overflow clamps out_data to 2^(INT_WIDTH-1)-1 and
//                 raises out_sat in the same output cycle.
//   not defined : results wrap in two's complement, out_sat is tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  [N_REQ]      requester i presents data
//   req_data   [N_REQ*W]    signed fixed-point inputs, slice i at [i*W +: W]
//   req_ready  [N_REQ]      one-hot-or-zero grant (combinational)
//   out_valid  1            one-cycle result pulse
//   out_id     [$clog2(N)]  owner of the result
//   out_data   [INT_WIDTH]  signed rounded result
//   out_sat    1            result was clamped (macro only)
//   idle       1            nothing in flight
//
// signed_rounder
//   Rounds a signed INT.FRAC value to an integer. "FLOOR" is combinational
//   (latency 0); "CEIL", "TRUNC", "HALF_UP" and "HALF_EVEN" take 2 cycles.
// ----------------------------------------------------------------------------

module signed_rounder #(
  parameter int    int_width  = 8,
  parameter int    frac_width = 4,
  parameter string method     = "HALF_EVEN"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [int_width+frac_width-1:0] i_data,
  output logic [int_width-1:0]            o_data
);
  localparam bit IS_FLOOR = (method == "FLOOR");
  localparam int HALF_I   = 1 << (frac_width - 1);
  localparam logic [frac_width-1:0] HALF = HALF_I[frac_width-1:0];

  logic [int_width-1:0]  w_floor;
  logic [frac_width-1:0] w_frac;
  logic                  w_inc;

  // Dropping the fraction bits is an arithmetic shift, i.e. floor().
  assign w_floor = i_data[int_width+frac_width-1:frac_width];
  assign w_frac  = i_data[frac_width-1:0];

  // Decide whether floor() must be bumped by one for the chosen method.
  always_comb begin
    w_inc = 1'b0;
    if (method == "CEIL") begin
      w_inc = |w_frac;
    end else if (method == "TRUNC") begin
      w_inc = i_data[int_width+frac_width-1] & (|w_frac);
    end else if (method == "HALF_UP") begin
      w_inc = (w_frac >= HALF);
    end else if (method == "HALF_EVEN") begin
      w_inc = (w_frac > HALF) | ((w_frac == HALF) & w_floor[0]);
    end else begin
      w_inc = 1'b0;
    end
  end

  if (IS_FLOOR) begin : g_comb
    assign o_data = w_floor;
  end else begin : g_pipe
    logic [int_width-1:0] r_floor;
    logic                 r_inc;
    logic [int_width-1:0] r_sum;

    // Stage 1 captures floor/increment, stage 2 the sum.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_floor <= '0;
        r_inc   <= 1'b0;
        r_sum   <= '0;
      end else begin
        r_floor <= w_floor;
        r_inc   <= w_inc;
        r_sum   <= r_floor + {{(int_width-1){1'b0}}, r_inc};
      end
    end

    assign o_data = r_sum;
  end
endmodule

module rounding_arbiter #(
  parameter int    N_REQ      = 4,
  parameter int    INT_WIDTH  = 8,
  parameter int    FRAC_WIDTH = 4,
  parameter string METHOD     = "HALF_EVEN",
  parameter int    LATENCY    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ*(INT_WIDTH+FRAC_WIDTH)-1:0] req_data,
  output logic [N_REQ-1:0]                      req_ready,
  output logic                                  out_valid,
  output logic [$clog2(N_REQ)-1:0]              out_id,
  output logic [INT_WIDTH-1:0]                  out_data,
  output logic                                  out_sat,
  output logic                                  idle
);
  localparam int W   = INT_WIDTH + FRAC_WIDTH;
  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  logic [IDW-1:0]       r_ptr;
  logic                 w_gnt_any;
  logic [IDW-1:0]       w_gnt_idx;
  logic [W-1:0]         w_gnt_data;
  int                   w_scan;
  logic [IDW-1:0]       w_scan_idx;

  logic                 r_iss_valid;
  logic [IDW-1:0]       r_iss_id;
  logic [W-1:0]         r_iss_data;

  logic                 w_end_valid;
  logic [IDW-1:0]       w_end_id;
  logic                 w_tag_busy;
  logic [INT_WIDTH-1:0] w_rnd;

  logic                 r_out_valid;
  logic [IDW-1:0]       r_out_id;
  logic [INT_WIDTH-1:0] r_out_data;

  // Round-robin search from r_ptr upwards, wrapping; no grant during reset.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_scan     = 0;
    w_scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan     = (int'(r_ptr) + k >= N_REQ) ? int'(r_ptr) + k - N_REQ : int'(r_ptr) + k;
      w_scan_idx = w_scan[IDW-1:0];
      if (!rst && !w_gnt_any && req_valid[w_scan_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan_idx;
      end else begin
        w_gnt_any = w_gnt_any;
      end
    end
  end

  assign req_ready  = w_gnt_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
  assign w_gnt_data = req_data[w_gnt_idx*W +: W];

  // Pointer moves past the winner; holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_gnt_any) begin
      r_ptr <= (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Issue register: feeds the rounder and heads the tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_id    <= '0;
      r_iss_data  <= '0;
    end else if (w_gnt_any) begin
      r_iss_valid <= 1'b1;
      r_iss_id    <= w_gnt_idx;
      r_iss_data  <= w_gnt_data;
    end else begin
      r_iss_valid <= 1'b0;
    end
  end

  signed_rounder #(
    .int_width  (INT_WIDTH),
    .frac_width (FRAC_WIDTH),
    .method     (METHOD)
  ) u_rounder (
    .clk    (clk),
    .rst    (rst),
    .i_data (r_iss_data),
    .o_data (w_rnd)
  );

`ifdef ROUNDING_ARB_SAT_EN
  logic w_end_sign;
`endif

  if (LATENCY > 0) begin : g_tag
    logic [LATENCY-1:0] r_tag_valid;
    logic [IDW-1:0]     r_tag_id [LATENCY];
`ifdef ROUNDING_ARB_SAT_EN
    logic [LATENCY-1:0] r_tag_sign;
`endif

    // Tag shift register, in step with the rounder stages.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_tag_valid <= '0;
        for (int k = 0; k < LATENCY; k++) r_tag_id[k] <= '0;
`ifdef ROUNDING_ARB_SAT_EN
        r_tag_sign  <= '0;
`endif
      end else begin
        r_tag_valid[0] <= r_iss_valid;
        r_tag_id[0]    <= r_iss_id;
`ifdef ROUNDING_ARB_SAT_EN
        r_tag_sign[0]  <= r_iss_data[W-1];
`endif
        for (int k = 1; k < LATENCY; k++) begin
          r_tag_valid[k] <= r_tag_valid[k-1];
          r_tag_id[k]    <= r_tag_id[k-1];
`ifdef ROUNDING_ARB_SAT_EN
          r_tag_sign[k]  <= r_tag_sign[k-1];
`endif
        end
      end
    end

    assign w_end_valid = r_tag_valid[LATENCY-1];
    assign w_end_id    = r_tag_id[LATENCY-1];
    assign w_tag_busy  = |r_tag_valid;
`ifdef ROUNDING_ARB_SAT_EN
    assign w_end_sign  = r_tag_sign[LATENCY-1];
`endif
  end else begin : g_notag
    assign w_end_valid = r_iss_valid;
    assign w_end_id    = r_iss_id;
    assign w_tag_busy  = 1'b0;
`ifdef ROUNDING_ARB_SAT_EN
    assign w_end_sign  = r_iss_data[W-1];
`endif
  end

`ifdef ROUNDING_ARB_SAT_EN
  localparam logic [INT_WIDTH-1:0] SAT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  logic w_ovf;
  logic r_out_sat;
  // Non-negative input with a negative result is the carry past the maximum.
  assign w_ovf = ~w_end_sign & w_rnd[INT_WIDTH-1];
`endif

  // Output register: result plus tag from the end of the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
`ifdef ROUNDING_ARB_SAT_EN
      r_out_sat   <= 1'b0;
`endif
    end else begin
      r_out_valid <= w_end_valid;
      r_out_id    <= w_end_id;
`ifdef ROUNDING_ARB_SAT_EN
      r_out_data  <= w_ovf ? SAT_MAX : w_rnd;
      r_out_sat   <= w_end_valid & w_ovf;
`else
      r_out_data  <= w_rnd;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign out_data  = r_out_data;
`ifdef ROUNDING_ARB_SAT_EN
  assign out_sat   = r_out_sat;
`else
  assign out_sat   = 1'b0;
`endif
  assign idle      = ~(r_iss_valid | w_tag_busy | r_out_valid);
endmodule
